// File: rtl/ticktocktokens_core.sv
// Token-counting spiking-neuron array behind the TinyTapeout user pin set.
// ADD ticks tokens into one neuron; TOCK fires and drains every neuron at once.
module ticktocktokens_core #(
  parameter int NUM_NEURONS = 8,
  parameter int TOKEN_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ADD  = 2'b01,
    OP_CFG  = 2'b10,
    OP_TOCK = 2'b11
  } op_e;

  logic signed [TOKEN_WIDTH-1:0] count [NUM_NEURONS];
  logic signed [TOKEN_WIDTH-1:0] thr   [NUM_NEURONS];
  logic        [NUM_NEURONS-1:0] spikes;

  op_e         op;
  logic [2:0]  addr;
  logic        rd_sel;
  logic        unused_rsv;

  assign op         = op_e'(ui_in[4:3]);
  assign addr       = ui_in[2:0];
  assign rd_sel     = ui_in[5];
  assign unused_rsv = ^ui_in[7:6];

  // Clamp a one-bit-wider signed result back into TOKEN_WIDTH two's complement.
  function automatic logic signed [TOKEN_WIDTH-1:0] sat(input logic signed [TOKEN_WIDTH:0] v);
    if (v[TOKEN_WIDTH] != v[TOKEN_WIDTH-1])
      return v[TOKEN_WIDTH] ? {1'b1, {(TOKEN_WIDTH-1){1'b0}}}
                            : {1'b0, {(TOKEN_WIDTH-1){1'b1}}};
    return v[TOKEN_WIDTH-1:0];
  endfunction

  logic signed [TOKEN_WIDTH:0]   add_sum;
  logic signed [TOKEN_WIDTH-1:0] add_next;
  logic signed [TOKEN_WIDTH:0]   tock_diff [NUM_NEURONS];
  logic signed [TOKEN_WIDTH-1:0] tock_next [NUM_NEURONS];
  logic        [NUM_NEURONS-1:0] fire;

  always_comb begin
    add_sum  = {count[addr][TOKEN_WIDTH-1], count[addr]}
             + {uio_in[TOKEN_WIDTH-1], uio_in};
    add_next = sat(add_sum);
  end

  always_comb begin
    fire = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      tock_diff[i] = {count[i][TOKEN_WIDTH-1], count[i]}
                   - {thr[i][TOKEN_WIDTH-1], thr[i]};
      fire[i]      = (count[i] >= thr[i]);
      tock_next[i] = fire[i] ? sat(tock_diff[i]) : count[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        count[i] <= '0;
        thr[i]   <= TOKEN_WIDTH'(1);
      end
      spikes <= '0;
    end else if (ena) begin
      case (op)
        OP_ADD: count[addr] <= add_next;
        OP_CFG: thr[addr]   <= uio_in;
        OP_TOCK: begin
          for (int unsigned i = 0; i < NUM_NEURONS; i++)
            count[i] <= tock_next[i];
          spikes <= fire;
        end
        default: ;
      endcase
    end
  end

  // Readback mux is purely combinational and deliberately ignores ena.
  assign uo_out  = rd_sel ? count[addr] : spikes;
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_ticktocktokens_core.sv
// Directed bench for ticktocktokens_core: a per-neuron integer model is
// checked against uo_out on every falling edge, plus literal spot checks.
module tb_ticktocktokens_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;
  bit run   = 1'b0;

  int         m_cnt [8];
  int         m_thr [8];
  logic [7:0] m_spk;

  ticktocktokens_core #(.NUM_NEURONS(8), .TOKEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_thr[i] = 1;
    end
    m_spk = 8'h00;
  endfunction

  function automatic logic [7:0] exp_out();
    int v;
    logic [7:0] b;
    if (ui_in[5]) begin
      v = m_cnt[ui_in[2:0]];
      b = v[7:0];
      return b;
    end
    return m_spk;
  endfunction

  // Applies the command rules to the model as one atomic step.
  function automatic void model_step(input logic en, input logic [1:0] op,
                                     input logic [2:0] a, input logic [7:0] d);
    int sd;
    int nxt [8];
    logic [7:0] sp;
    sd = $signed(d);
    if (!en) return;
    case (op)
      2'b01: m_cnt[a] = clamp(m_cnt[a] + sd);
      2'b10: m_thr[a] = sd;
      2'b11: begin
        for (int i = 0; i < 8; i++) begin
          sp[i]  = (m_cnt[i] >= m_thr[i]);
          nxt[i] = sp[i] ? clamp(m_cnt[i] - m_thr[i]) : m_cnt[i];
        end
        for (int i = 0; i < 8; i++) m_cnt[i] = nxt[i];
        m_spk = sp;
      end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (run) begin
      logic [7:0] e;
      e = exp_out();
      tests++;
      if (uo_out !== e) begin
        fails++;
        $display("FAIL model_uo_out t=%0t ui_in=%h got %h expected %h", $time, ui_in, uo_out, e);
      end
      tests++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        fails++;
        $display("FAIL model_uio t=%0t got uio_out=%h uio_oe=%h expected 00/00", $time, uio_out, uio_oe);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmd(input logic en, input logic [1:0] op, input logic [2:0] a,
                     input logic [7:0] d, input logic rd = 1'b0, input logic [1:0] rsv = 2'b00);
    ena    = en;
    ui_in  = {rsv, rd, op, a};
    uio_in = d;
    @(posedge clk);
    model_step(en, op, a, d);
    #1;
  endtask

  task automatic peek(input string name, input logic [7:0] ui, input logic [7:0] exp,
                      input logic en = 1'b1);
    ena    = en;
    ui_in  = ui;
    uio_in = 8'h00;
    #2;
    check(name, uo_out, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    ui_in = 8'h00;
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    #3;
    check("reset_spikes", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    ui_in = 8'h23;
    #1;
    check("reset_read_n3", uo_out, 8'h00);
    run = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    ui_in = 8'h00;
    rst   = 1'b0;

    // Basic spike sequence
    cmd(1, 2'b10, 3'd2, 8'd5);
    cmd(1, 2'b01, 3'd2, 8'd3);
    cmd(1, 2'b01, 3'd2, 8'd3, 1'b1, 2'b11);
    peek("basic_cnt2_pre", 8'h22, 8'h06);
    cmd(1, 2'b11, 3'd0, 8'h00);
    peek("basic_tock1_spk", 8'h00, 8'h04);
    peek("basic_tock1_cnt2", 8'h22, 8'h01);
    cmd(1, 2'b11, 3'd5, 8'h00);
    peek("basic_tock2_spk", 8'h00, 8'h00);
    peek("basic_tock2_cnt2", 8'h22, 8'h01);

    // Saturation
    cmd(1, 2'b01, 3'd0, 8'd100);
    cmd(1, 2'b01, 3'd0, 8'd100);
    peek("sat_cnt0_hi", 8'h20, 8'h7F);
    for (int k = 0; k < 3; k++) cmd(1, 2'b01, 3'd1, 8'h80);
    peek("sat_cnt1_lo", 8'h21, 8'h80);
    cmd(1, 2'b11, 3'd0, 8'h00);
    peek("sat_tock_spk", 8'h00, 8'h01);
    peek("sat_tock_cnt0", 8'h20, 8'h7E);
    peek("sat_tock_cnt1", 8'h21, 8'h80);

    // Non-positive threshold
    cmd(1, 2'b10, 3'd4, 8'hFB);
    cmd(1, 2'b11, 3'd0, 8'h00);
    peek("npthr_spk", 8'h00, 8'h11);
    peek("npthr_cnt4", 8'h24, 8'h05);
    for (int k = 0; k < 30; k++) cmd(1, 2'b11, 3'd0, 8'h00);
    peek("npthr_cnt4_sat", 8'h24, 8'h7F);
    peek("npthr_cnt0_drain", 8'h20, 8'h5F);

    // Enable gating
    cmd(0, 2'b01, 3'd6, 8'd10);
    cmd(0, 2'b11, 3'd0, 8'h00);
    peek("ena0_cnt6", 8'h26, 8'h00, 1'b0);
    peek("ena0_spk", 8'h00, 8'h11, 1'b0);

    // Reset mid-operation
    pulse_reset();
    cmd(1, 2'b01, 3'd0, 8'd1);
    cmd(1, 2'b01, 3'd2, 8'd1);
    cmd(1, 2'b11, 3'd0, 8'h00);
    peek("pre_rst_spk", 8'h00, 8'h05);
    ui_in = 8'h18;
    pulse_reset();
    peek("post_rst_spk", 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) peek("post_rst_cnt", 8'h20 | 8'(i), 8'h00);
    cmd(1, 2'b01, 3'd3, 8'd1);
    cmd(1, 2'b11, 3'd0, 8'h00);
    peek("post_rst_thr", 8'h00, 8'h08);

    // Negative ADD from a positive count and reserved bits set
    cmd(1, 2'b01, 3'd7, 8'd20, 1'b1, 2'b10);
    cmd(1, 2'b01, 3'd7, 8'hE2);
    peek("neg_add_cnt7", 8'hE7, 8'hF6);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
